vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle of VGA timing outputs shared by the timing generator (master) and
// the pixel colour logic (slave).
//   pix_en        : one-clk strobe per pixel period
//   hsync, vsync  : sync levels (polarity set by the generator)
//   counterX/Y    : current pixel column / line
//   inDisplayArea : current coordinate lies in the visible region
//   frame_start   : one-clk pulse when the counters become (0,0)
//   line_start    : one-clk pulse when counterX becomes 0
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic [9:0] counterX;
    logic [9:0] counterY;
    logic       inDisplayArea;
    logic       frame_start;
    logic       line_start;

    modport master (
        output pix_en, hsync, vsync, counterX, counterY,
               inDisplayArea, frame_start, line_start
    );

    modport slave (
        input  pix_en, hsync, vsync, counterX, counterY,
               inDisplayArea, frame_start, line_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA timing stage: divides the system clock down to a pixel-enable strobe
// and walks pixel/line counters through the configured raster, producing
// sync, display-area and frame/line start flags that always describe the
// current counter values (no skew between coordinates and flags).
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-high
//   vga : timing outputs (master modport of vga_timing_gen_if)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_gen_if.master   vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024");
        end
        if (CLK_DIV < 2) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be >= 2");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_en_q, pix_en_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             disp_q, disp_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // All flags are decoded from the next-state counters so that they land
    // on the same edge as the coordinates they describe.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        // pix_en is registered: high in the cycle where div_cnt == CLK_DIV-1.
        pix_en_d  = (div_cnt_d == DIV_LAST);

        x_d = x_q;
        y_d = y_q;
        if (pix_en_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        hsync_d       = (x_d >= HS_START && x_d <= HS_END) ? SYNC_ACT : ~SYNC_ACT;
        vsync_d       = (y_d >= VS_START && y_d <= VS_END) ? SYNC_ACT : ~SYNC_ACT;
        disp_d        = (x_d < H_VIS) && (y_d < V_VIS);
        // Only one clk wide: qualified by the pixel advance itself.
        line_start_d  = pix_en_q && (x_d == '0);
        frame_start_d = line_start_d && (y_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            pix_en_q      <= 1'b0;
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            disp_q        <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_en_q      <= pix_en_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            disp_q        <= disp_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pix_en        = pix_en_q;
    assign vga.hsync         = hsync_q;
    assign vga.vsync         = vsync_q;
    assign vga.counterX      = x_q;
    assign vga.counterY      = y_q;
    assign vga.inDisplayArea = disp_q;
    assign vga.frame_start   = frame_start_q;
    assign vga.line_start    = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances: default 640x480 timing and a tiny raster (CLK_DIV=4,
// 14x7 totals) so whole frames fit in a short run. Drivers issue reset
// stimulus (initial hold, random pulses, one directed mid-sync pulse) and
// push the expected post-edge outputs computed in closed form from the
// number of clocks since reset release; monitors pop and compare.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic       hsync;
        logic       vsync;
        logic [9:0] x;
        logic [9:0] y;
        logic       disp;
        logic       fs;
        logic       ls;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();

    vga_timing_gen u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (if_a.master)
    );

    vga_timing_gen #(
        .CLK_DIV (4),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (if_b.master)
    );

    int errors = 0;
    int checks = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    // Expected outputs k clocks after the last reset edge (k=0 is the reset
    // state). n pixel advances have completed by cycle k.
    function automatic exp_t model(longint k, int cd, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb);
        exp_t   e;
        longint ht = ha + hf + hs + hb;
        longint vt = va + vf + vs + vb;
        longint n = k / cd;
        longint x, y;
        if (n == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            x = (n - 1) % ht;
            y = ((n - 1) / ht) % vt;
        end
        e.x      = 10'(x);
        e.y      = 10'(y);
        e.pix_en = ((k % cd) == cd - 1);
        e.ls     = (k >= cd) && ((k % cd) == 0) && (x == 0);
        e.fs     = e.ls && (y == 0);
        e.hsync  = !((x >= ha + hf) && (x < ha + hf + hs));
        e.vsync  = !((y >= va + vf) && (y < va + vf + vs));
        e.disp   = (x < ha) && (y < va);
        return e;
    endfunction

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic cmp(string tag, exp_t a, exp_t e);
        chk({tag, ".pix_en"}, int'(a.pix_en), int'(e.pix_en));
        chk({tag, ".hsync"},  int'(a.hsync),  int'(e.hsync));
        chk({tag, ".vsync"},  int'(a.vsync),  int'(e.vsync));
        chk({tag, ".counterX"}, int'(a.x), int'(e.x));
        chk({tag, ".counterY"}, int'(a.y), int'(e.y));
        chk({tag, ".inDisplayArea"}, int'(a.disp), int'(e.disp));
        chk({tag, ".frame_start"}, int'(a.fs), int'(e.fs));
        chk({tag, ".line_start"},  int'(a.ls), int'(e.ls));
    endtask

    // Monitors: every cycle the DUT presents a new output set.
    always @(negedge clk) begin
        exp_t act;
        if (q_a.size() > 0) begin
            act = {if_a.pix_en, if_a.hsync, if_a.vsync, if_a.counterX, if_a.counterY,
                   if_a.inDisplayArea, if_a.frame_start, if_a.line_start};
            cmp("A", act, q_a.pop_front());
        end
        if (q_b.size() > 0) begin
            act = {if_b.pix_en, if_b.hsync, if_b.vsync, if_b.counterX, if_b.counterY,
                   if_b.inDisplayArea, if_b.frame_start, if_b.line_start};
            cmp("B", act, q_b.pop_front());
        end
    end

    initial begin
        fork
            begin : drv_a
                longint k = 0;
                exp_t   cur = model(0, 2, 640, 16, 96, 48, 480, 10, 2, 33);
                bit     done = 1'b0;
                int     hold = 0;
                logic   r;
                for (int c = 0; c < 12000; c++) begin
                    r = 1'b0;
                    if (c < 5) r = 1'b1;
                    else if (hold > 0) begin r = 1'b1; hold--; end
                    else if (!done && c > 1000 && cur.x == 10'd700) begin
                        r = 1'b1;
                        done = 1'b1;
                    end else if ($urandom_range(0, 2999) == 0) begin
                        r = 1'b1;
                        hold = int'($urandom_range(0, 2));
                    end
                    rst_a = r;
                    @(posedge clk);
                    k = r ? 0 : k + 1;
                    cur = model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
                    q_a.push_back(cur);
                    #1;
                end
                rst_a = 1'b0;
            end
            begin : drv_b
                longint k = 0;
                exp_t   cur = model(0, 4, 8, 2, 2, 2, 4, 1, 1, 1);
                bit     done = 1'b0;
                int     hold = 0;
                logic   r;
                for (int c = 0; c < 4000; c++) begin
                    r = 1'b0;
                    if (c < 5) r = 1'b1;
                    else if (hold > 0) begin r = 1'b1; hold--; end
                    else if (!done && c > 900 && cur.x == 10'd10 && cur.y == 10'd5) begin
                        r = 1'b1;
                        done = 1'b1;
                    end else if ($urandom_range(0, 1499) == 0) begin
                        r = 1'b1;
                        hold = int'($urandom_range(0, 2));
                    end
                    rst_b = r;
                    @(posedge clk);
                    k = r ? 0 : k + 1;
                    cur = model(k, 4, 8, 2, 2, 2, 4, 1, 1, 1);
                    q_b.push_back(cur);
                    #1;
                end
                rst_b = 1'b0;
            end
        join
        @(negedge clk);
        @(negedge clk);
        chk("A.queue_drained", q_a.size(), 0);
        chk("B.queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
